seg_scan_ctrl: RTL

//  Time-multiplexed scan controller for an N-digit common-anode 7-segment display.

---
 rtl/display_pkg.sv | 13 +
 rtl/time_display.sv | 25 ++
 rtl/seg_scan_ctrl.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared constants and scan state type for the segment display blocks
package display_pkg;

    localparam logic [6:0] SEG_BLANK = 7'b0000000;
    localparam logic [3:0] BCD_MAX   = 4'd9;

    typedef enum logic [1:0] {
        IDLE,
        BLANK,
        DRIVE
    } scan_state_t;

endpackage

// File: rtl/time_display.sv
// rtl/time_display.sv - combinational BCD to 7-segment decoder, segments {g,f,e,d,c,b,a}
module time_display (
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    // Codes above 9 show a dash; callers that need them dark mask the result.
    always_comb begin
        seg = 7'b1000000;
        case (bcd)
            4'd0: seg = 7'b0111111;
            4'd1: seg = 7'b0000110;
            4'd2: seg = 7'b1011011;
            4'd3: seg = 7'b1001111;
            4'd4: seg = 7'b1100110;
            4'd5: seg = 7'b1101101;
            4'd6: seg = 7'b1111101;
            4'd7: seg = 7'b0100111;
            4'd8: seg = 7'b1111111;
            4'd9: seg = 7'b1101111;
            default: seg = 7'b1000000;
        endcase
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - time-multiplexed N-digit 7-segment scan controller with frame-stable shadow
module seg_scan_ctrl
    import display_pkg::*;
#(
    parameter int N_DIGITS      = 4,
    parameter int DWELL_CYCLES  = 50000,
    parameter int BLANK_CYCLES  = 500,
    parameter bit AN_ACTIVE_LOW = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [4*N_DIGITS-1:0] digits_in,
    input  logic [N_DIGITS-1:0]   dp_in,
    input  logic                  load,
    output logic                  load_ack,
    input  logic                  lz_blank,
    output logic [6:0]            seg_out,
    output logic                  dp_out,
    output logic [N_DIGITS-1:0]   an_out,
    output logic                  frame_tick
);

    localparam int CNT_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int IW      = $clog2(N_DIGITS);

    localparam logic [CW-1:0]       DWELL_LOAD  = CW'(DWELL_CYCLES - 1);
    localparam logic [CW-1:0]       BLANK_LOAD  = (BLANK_CYCLES > 0) ? CW'(BLANK_CYCLES - 1) : '0;
    localparam scan_state_t         GAP_STATE   = (BLANK_CYCLES > 0) ? BLANK : DRIVE;
    localparam logic [CW-1:0]       GAP_LOAD    = (BLANK_CYCLES > 0) ? BLANK_LOAD : DWELL_LOAD;
    localparam logic [IW-1:0]       LAST_IDX    = IW'(N_DIGITS - 1);
    localparam logic [N_DIGITS-1:0] AN_OFF      = {N_DIGITS{AN_ACTIVE_LOW}};

    scan_state_t           state, state_nxt;
    logic [IW-1:0]         idx, idx_nxt;
    logic [CW-1:0]         cnt, cnt_nxt;
    logic [4*N_DIGITS-1:0] staging, shadow;
    logic [N_DIGITS-1:0]   staging_dp, shadow_dp;
    logic                  pending;

    logic                  ft_nxt;
    logic                  commit;
    logic [N_DIGITS-1:0]   lz_mask;
    logic                  zero_run;
    logic [3:0]            digit_sel;
    logic                  dp_sel;
    logic                  lz_sel;
    logic [6:0]            dec_seg;
    logic [6:0]            seg_nxt;
    logic                  dp_nxt;
    logic [N_DIGITS-1:0]   an_nxt;

    // Counter loads (length - 1) on every state entry and counts down to zero.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        cnt_nxt   = cnt;
        if (!en) begin
            state_nxt = IDLE;
            idx_nxt   = '0;
            cnt_nxt   = '0;
        end else begin
            case (state)
                IDLE: begin
                    state_nxt = GAP_STATE;
                    idx_nxt   = '0;
                    cnt_nxt   = GAP_LOAD;
                end
                BLANK: begin
                    if (cnt == '0) begin
                        state_nxt = DRIVE;
                        cnt_nxt   = DWELL_LOAD;
                    end else begin
                        cnt_nxt = cnt - 1'b1;
                    end
                end
                DRIVE: begin
                    if (cnt == '0) begin
                        state_nxt = GAP_STATE;
                        cnt_nxt   = GAP_LOAD;
                        idx_nxt   = (idx == LAST_IDX) ? '0 : idx + 1'b1;
                    end else begin
                        cnt_nxt = cnt - 1'b1;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    idx_nxt   = '0;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    // Shadow swaps on the edge that opens the frame's last dwell cycle, so the
    // digit already on screen keeps its old value and digit 0 of the next frame shows the new one.
    assign ft_nxt = (state_nxt == DRIVE) && (idx_nxt == LAST_IDX) && (cnt_nxt == '0);
    assign commit = pending && ((state == IDLE) || ft_nxt);

    always_comb begin
        zero_run = 1'b1;
        lz_mask  = '0;
        for (int i = N_DIGITS - 1; i >= 1; i--) begin
            zero_run   = zero_run && (shadow[4*i +: 4] == 4'd0);
            lz_mask[i] = zero_run;
        end
    end

    always_comb begin
        digit_sel = '0;
        dp_sel    = 1'b0;
        lz_sel    = 1'b0;
        an_nxt    = AN_OFF;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (idx_nxt == IW'(i)) begin
                digit_sel = shadow[4*i +: 4];
                dp_sel    = shadow_dp[i];
                lz_sel    = lz_mask[i];
            end
            an_nxt[i] = ((state_nxt == DRIVE) && (idx_nxt == IW'(i))) ^ AN_ACTIVE_LOW;
        end
    end

    time_display u_time_display (
        .bcd (digit_sel),
        .seg (dec_seg)
    );

    always_comb begin
        seg_nxt = dec_seg;
        if ((state_nxt != DRIVE) || (digit_sel > BCD_MAX) || (lz_blank && lz_sel)) begin
            seg_nxt = SEG_BLANK;
        end
        dp_nxt = (state_nxt == DRIVE) && dp_sel;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            idx        <= '0;
            cnt        <= '0;
            staging    <= '0;
            staging_dp <= '0;
            shadow     <= '0;
            shadow_dp  <= '0;
            pending    <= 1'b0;
            seg_out    <= SEG_BLANK;
            dp_out     <= 1'b0;
            an_out     <= AN_OFF;
            load_ack   <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            state      <= state_nxt;
            idx        <= idx_nxt;
            cnt        <= cnt_nxt;
            seg_out    <= seg_nxt;
            dp_out     <= dp_nxt;
            an_out     <= an_nxt;
            frame_tick <= ft_nxt;
            load_ack   <= commit;
            if (commit) begin
                shadow    <= staging;
                shadow_dp <= staging_dp;
            end
            if (load) begin
                staging    <= digits_in;
                staging_dp <= dp_in;
            end
            pending <= load | (pending & ~commit);
        end
    end

endmodule
